// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 constants: register addresses, exception codes and field positions.
package cp0_regfile_pkg;

    // Register numbers encoded as {rd[4:0], sel[2:0]}
    localparam logic [7:0] CP0_BADVADDR = 8'h40;  // (8,0)
    localparam logic [7:0] CP0_COUNT    = 8'h48;  // (9,0)
    localparam logic [7:0] CP0_COMPARE  = 8'h58;  // (11,0)
    localparam logic [7:0] CP0_STATUS   = 8'h60;  // (12,0)
    localparam logic [7:0] CP0_CAUSE    = 8'h68;  // (13,0)
    localparam logic [7:0] CP0_EPC      = 8'h70;  // (14,0)

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // Status field positions
    localparam int unsigned STATUS_BEV   = 22;
    localparam int unsigned STATUS_IM_LO = 8;
    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned STATUS_IE    = 0;

    // Cause field positions
    localparam int unsigned CAUSE_BD     = 31;
    localparam int unsigned CAUSE_TI     = 30;
    localparam int unsigned CAUSE_IPH_LO = 10;
    localparam int unsigned CAUSE_IPS_LO = 8;
    localparam int unsigned CAUSE_EXC_LO = 2;

    // Address-error exceptions are the only ones that capture BadVAddr
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause and EPC with
// exception/ERET commit, Count/Compare timer and interrupt-pending output.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter bit TIMER_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mtc0_we,
    input  logic [7:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic        wb_ex,
    input  logic [4:0]  wb_excode,
    input  logic        wb_bd,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_badvaddr,
    input  logic        eret_flush,
    input  logic [5:0]  ext_int,
    output logic [31:0] epc_out,
    output logic        has_int,
    output logic        status_exl
);

    logic [7:0]  status_im_q;
    logic        status_exl_q;
    logic        status_ie_q;
    logic        cause_bd_q;
    logic        cause_ti_q;
    logic [5:0]  cause_iph_q;   // IP[7:2], sampled from the interrupt lines
    logic [1:0]  cause_ips_q;   // IP[1:0], software interrupts
    logic [4:0]  cause_exc_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        tick_q;

    // A committing exception drops any MTC0 in the same cycle
    logic wr;
    assign wr = mtc0_we & ~wb_ex;

    // Status: EXL set by exceptions, cleared by ERET, otherwise software-written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_im_q  <= '0;
            status_exl_q <= 1'b0;
            status_ie_q  <= 1'b0;
        end else begin
            if (wr && cp0_addr == CP0_STATUS) begin
                status_im_q <= cp0_wdata[STATUS_IM_LO +: 8];
                status_ie_q <= cp0_wdata[STATUS_IE];
            end
            if (wb_ex) begin
                status_exl_q <= 1'b1;
            end else if (eret_flush) begin
                status_exl_q <= 1'b0;
            end else if (wr && cp0_addr == CP0_STATUS) begin
                status_exl_q <= cp0_wdata[STATUS_EXL];
            end
        end
    end

    // Cause: hardware IP lines, software IP, BD and ExcCode capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_iph_q <= '0;
            cause_ips_q <= '0;
            cause_bd_q  <= 1'b0;
            cause_exc_q <= '0;
        end else begin
            cause_iph_q <= {ext_int[5] | cause_ti_q, ext_int[4:0]};
            if (wr && cp0_addr == CP0_CAUSE) begin
                cause_ips_q <= cp0_wdata[CAUSE_IPS_LO +: 2];
            end
            if (wb_ex) begin
                cause_exc_q <= wb_excode;
                // Nested exceptions keep the original BD/EPC
                if (!status_exl_q) begin
                    cause_bd_q <= wb_bd;
                end
            end
        end
    end

    // Timer interrupt flag: sticky on match, cleared only by a Compare write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_ti_q <= 1'b0;
        end else if (wr && cp0_addr == CP0_COMPARE) begin
            cause_ti_q <= 1'b0;
        end else if (TIMER_EN && count_q == compare_q) begin
            cause_ti_q <= 1'b1;
        end
    end

    // EPC and BadVAddr capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            if (wb_ex && !status_exl_q) begin
                epc_q <= wb_bd ? wb_pc - 32'd4 : wb_pc;
            end else if (wr && cp0_addr == CP0_EPC) begin
                epc_q <= cp0_wdata;
            end
            if (wb_ex && is_addr_exc(wb_excode)) begin
                badvaddr_q <= wb_badvaddr;
            end
        end
    end

    // Count runs at half clock rate; a software write overrides the increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q    <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
        end else begin
            tick_q <= ~tick_q;
            if (wr && cp0_addr == CP0_COUNT) begin
                count_q <= cp0_wdata;
            end else if (tick_q) begin
                count_q <= count_q + 32'd1;
            end
            if (wr && cp0_addr == CP0_COMPARE) begin
                compare_q <= cp0_wdata;
            end
        end
    end

    // MFC0 read mux; unimplemented addresses read 0
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_COUNT:    cp0_rdata = count_q;
            CP0_COMPARE:  cp0_rdata = compare_q;
            CP0_STATUS: begin
                cp0_rdata[STATUS_BEV]          = 1'b1;
                cp0_rdata[STATUS_IM_LO +: 8]   = status_im_q;
                cp0_rdata[STATUS_EXL]          = status_exl_q;
                cp0_rdata[STATUS_IE]           = status_ie_q;
            end
            CP0_CAUSE: begin
                cp0_rdata[CAUSE_BD]            = cause_bd_q;
                cp0_rdata[CAUSE_TI]            = cause_ti_q;
                cp0_rdata[CAUSE_IPH_LO +: 6]   = cause_iph_q;
                cp0_rdata[CAUSE_IPS_LO +: 2]   = cause_ips_q;
                cp0_rdata[CAUSE_EXC_LO +: 5]   = cause_exc_q;
            end
            CP0_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = '0;
        endcase
    end

    assign epc_out    = epc_q;
    assign status_exl = status_exl_q;
    assign has_int    = (|({cause_iph_q, cause_ips_q} & status_im_q)) & status_ie_q
                        & ~status_exl_q;

endmodule

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL have parameter TIMER_EN, default 1: when 1, Count/Compare timer interrupt logic is present; when 0, TI is tied to 0.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port mtc0_we, input, 1 bit: MTC0 write strobe, sampled at the writeback stage.
REQ-005 SHALL have port cp0_addr, input, 8 bits: the register number {rd[4:0], sel[2:0]}.
REQ-006 SHALL have port cp0_wdata, input, 32 bits: the MTC0 write data.
REQ-007 SHALL have port cp0_rdata, output, 32 bits: combinational MFC0 read of cp0_addr.
REQ-008 SHALL have port wb_ex, input, 1 bit: exception commit; the cause comes from wb_excode[4:0].
REQ-009 SHALL have port wb_excode, input, 5 bits: the exception code of the committing exception.
REQ-010 SHALL have port wb_bd, input, 1 bit: the faulting instruction is in a branch delay slot.
REQ-011 SHALL have port wb_pc, input, 32 bits: the PC of the faulting instruction.
REQ-012 SHALL have port wb_badvaddr, input, 32 bits: the faulting address for AdEL/AdES.
REQ-013 SHALL have port eret_flush, input, 1 bit: ERET commit.
REQ-014 SHALL have port ext_int, input, 6 bits: hardware interrupt lines, level-sensitive.
REQ-015 SHALL have port epc_out, output, 32 bits: the current EPC, the ERET target.
REQ-016 SHALL have port has_int, output, 1 bit: an interrupt is pending and enabled.
REQ-017 SHALL have port status_exl, output, 1 bit: the current Status.EXL.

Function
REQ-018 SHALL implement BadVAddr (8,0), Count (9,0), Compare (11,0), Status (12,0), Cause (13,0) and EPC (14,0); reads of any other address SHALL return 0.
REQ-019 Status SHALL have these fields:
- BEV (bit 22): read-only 1.
- IM[7:0] (bits 15:8): read/write.
- EXL (bit 1): read/write.
- IE (bit 0): read/write.
- All other bits: read 0.
REQ-020 Cause SHALL have these fields:
- BD (bit 31): hardware-written only.
- TI (bit 30): hardware-written only.
- IP[7:2] (bits 15:10): hardware-written only.
- IP[1:0] (bits 9:8): software-writable.
- ExcCode (bits 6:2): hardware-written only.
- All other bits: read 0.
REQ-021 Cause.IP[7:2] SHALL be registered each cycle from {ext_int[5] | TI, ext_int[4:0]}, giving one cycle of latency.
REQ-022 On wb_ex with Status.EXL=0: Status.EXL:=1, Cause.BD:=wb_bd, Cause.ExcCode:=wb_excode, and EPC:=wb_bd ? wb_pc-4 : wb_pc (modulo 2^32).
REQ-023 On wb_ex with Status.EXL=1: only ExcCode SHALL update; EPC and BD SHALL hold.
REQ-024 BadVAddr SHALL load wb_badvaddr only when wb_ex and wb_excode is 0x04 (AdEL) or 0x05 (AdES).
REQ-025 The codes 0x00 Int, 0x04 AdEL, 0x05 AdES, 0x08 Sys, 0x09 Bp, 0x0A RI and 0x0C Ov SHALL be accepted; any other code SHALL still update ExcCode.
REQ-026 On eret_flush without wb_ex, Status.EXL SHALL be set to 0.
REQ-027 When wb_ex and eret_flush are asserted together, wb_ex SHALL win.
REQ-028 When mtc0_we and wb_ex are asserted in the same cycle, the exception update SHALL win for every field it touches; the MTC0 write SHALL be dropped.
REQ-029 An MTC0 to EPC SHALL be visible on epc_out in the next cycle.
REQ-030 A one-bit tick SHALL toggle every cycle; Count SHALL increment on cycles where tick=1, i.e. at half the clock rate.
REQ-031 Count SHALL wrap from 0xFFFF_FFFF to 0.
REQ-032 An MTC0 to Count SHALL override the increment in that cycle.
REQ-033 TI SHALL set when Count==Compare and TIMER_EN=1, and SHALL stay set until an MTC0 to Compare clears it.
REQ-034 If an MTC0 to Compare and a Count==Compare match occur in the same cycle, the clear SHALL win.
REQ-035 has_int SHALL equal |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL, combinationally from registered state.

Reset
REQ-036 Reset SHALL asynchronously set Status to 0x0040_0000, Cause to 0, tick to 0 and Count to 0.
REQ-037 EPC, BadVAddr and Compare SHALL reset to 0.
REQ-038 At reset: has_int=0, status_exl=0, epc_out=0.
REQ-039 Reset asserted mid-operation SHALL discard any same-cycle write or exception.

Structure
REQ-040 The shared package SHALL hold:
- the CP0 address constants;
- the ExcCode constants;
- the Status and Cause bit-position constants.
REQ-041 The block SHALL be a single module with no sub-module; the Count/Compare timer may be split out as cp0_timer if TIMER_EN grows.

Verification
REQ-042 Scenario, AdEL capture: wb_ex=1, wb_excode=0x04, wb_pc=0xBFC0_0100, wb_bd=0, wb_badvaddr=0x8000_0003 -> next cycle EPC=0xBFC0_0100, BadVAddr=0x8000_0003, Cause=0x0000_0010, status_exl=1.
REQ-043 Scenario, delay slot then nested exception: wb_ex with code 0x05, wb_bd=1, wb_pc=0xBFC0_0208 -> EPC=0xBFC0_0204 and Cause.BD=1; then a second wb_ex with code 0x08 -> EPC unchanged, ExcCode=0x08.
REQ-044 Scenario, write/exception collision: MTC0 EPC=0x1234_5678 together with wb_ex at wb_pc=0xBFC0_0000 -> EPC=0xBFC0_0000.
REQ-045 Scenario, timer interrupt: write Compare=10, Count=0, Status=0x0040_8001 -> TI=1 about 20 cycles later and has_int=1 one cycle later; MTC0 Compare -> TI=0.
REQ-046 Scenario, ERET and reset: ERET -> status_exl=0; then assert reset asynchronously mid-cycle -> Status reads 0x0040_0000 immediately.
